// File: rtl/scan_pkg.sv
// Shared types and helpers for the seven-segment digit scan controller.
package scan_pkg;

    typedef enum logic [1:0] {IDLE, ON, GUARD} scan_state_t;

    localparam int unsigned MAX_DIG = 5;

    // Active-low anode pattern with only digit `sel` driven low.
    function automatic logic [4:0] onehot_n(input logic [2:0] sel);
        return ~(5'b00001 << sel);
    endfunction

    // Digit counts outside 1..MAX_DIG fall back to a full scan.
    function automatic logic [2:0] norm_count(input logic [2:0] n);
        return (n == 3'd0 || n > 3'(MAX_DIG)) ? 3'(MAX_DIG) : n;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running up counter 0..LIMIT-1 with synchronous clear and terminal-count flag.
module scan_prescaler #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt_q;

    assign tc = (cnt_q == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scanner: steps the mux select, drives active-low anodes
// with a dark guard between digits, and flags each frame wrap.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned CLK_DIV = 100000,
    parameter int unsigned DEAD    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] n_active,
    input  logic [4:0] blank_mask,
    output logic [3:0] sel,
    output logic [4:0] an,
    output logic       frame_done
);

    localparam bit          HAS_GUARD = (DEAD > 0);
    localparam int unsigned GUARD_LEN = (DEAD > 0) ? DEAD : 1;

    scan_state_t state_q, state_d;
    logic [2:0]  sel_q, sel_d, next_sel;
    logic [2:0]  dig_cnt_q, dig_cnt_d;
    logic [4:0]  an_q, an_d;
    logic        frame_done_q, frame_done_d;
    logic        wrap;
    logic        dwell_run, dwell_clr, dwell_tc;
    logic        guard_run, guard_clr, guard_tc;

    // Counters sit at zero outside their own state, so each slot starts fresh.
    assign dwell_run = (state_q == ON);
    assign dwell_clr = !en || (state_q != ON);
    assign guard_run = (state_q == GUARD);
    assign guard_clr = !en || (state_q != GUARD);

    scan_prescaler #(
        .LIMIT(CLK_DIV)
    ) u_dwell (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (dwell_run),
        .clr  (dwell_clr),
        .tc   (dwell_tc)
    );

    scan_prescaler #(
        .LIMIT(GUARD_LEN)
    ) u_guard (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (guard_run),
        .clr  (guard_clr),
        .tc   (guard_tc)
    );

    assign wrap     = (sel_q == dig_cnt_q - 3'd1);
    assign next_sel = wrap ? 3'd0 : sel_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        dig_cnt_d    = dig_cnt_q;
        frame_done_d = 1'b0;

        if (!en) begin
            state_d = IDLE;
            sel_d   = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = ON;
                    sel_d     = 3'd0;
                    dig_cnt_d = norm_count(n_active);
                end
                ON: begin
                    if (dwell_tc) begin
                        // Select moves as the anode goes dark so the mux settles unlit.
                        sel_d        = next_sel;
                        frame_done_d = wrap;
                        if (wrap) begin
                            dig_cnt_d = norm_count(n_active);
                        end
                        state_d = HAS_GUARD ? GUARD : ON;
                    end
                end
                GUARD: begin
                    if (guard_tc) begin
                        state_d = ON;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = 3'd0;
                end
            endcase
        end

        an_d = 5'b11111;
        if (state_d == ON && !blank_mask[sel_d]) begin
            an_d = onehot_n(sel_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 3'd0;
            dig_cnt_q    <= 3'(MAX_DIG);
            an_q         <= 5'b11111;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            dig_cnt_q    <= dig_cnt_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = {1'b0, sel_q};
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Randomised bench for digit_scan_ctrl: two instances (with and without guard)
// checked every cycle against a slot-timeline reference model.
module tb_digit_scan_ctrl;

    localparam int unsigned DIV_A  = 4;
    localparam int unsigned DEAD_A = 1;
    localparam int unsigned DIV_B  = 3;
    localparam int unsigned DEAD_B = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] n_active;
    logic [4:0] blank_mask;

    logic [3:0] sel_a, sel_b;
    logic [4:0] an_a, an_b;
    logic       fd_a, fd_b;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: position within the slot timeline per instance
    int unsigned m_div [2];
    int unsigned m_dead[2];
    bit          m_act [2];
    int unsigned m_t   [2];
    int unsigned m_d   [2];
    int unsigned m_n   [2];
    logic [3:0]  e_sel [2];
    logic [4:0]  e_an  [2];
    logic        e_fd  [2];

    always #5 clk = ~clk;

    digit_scan_ctrl #(
        .CLK_DIV(DIV_A),
        .DEAD   (DEAD_A)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .n_active  (n_active),
        .blank_mask(blank_mask),
        .sel       (sel_a),
        .an        (an_a),
        .frame_done(fd_a)
    );

    digit_scan_ctrl #(
        .CLK_DIV(DIV_B),
        .DEAD   (DEAD_B)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .n_active  (n_active),
        .blank_mask(blank_mask),
        .sel       (sel_b),
        .an        (an_b),
        .frame_done(fd_b)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int unsigned norm(input int unsigned v);
        return (v >= 1 && v <= 5) ? v : 5;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_t[i]   = 0;
            m_d[i]   = 0;
            m_n[i]   = 5;
            e_sel[i] = 4'd0;
            e_an[i]  = 5'h1f;
            e_fd[i]  = 1'b0;
        end
    endtask

    // Slot of length div+dead: lit for t < div, dark afterwards; the digit
    // advances as the slot goes dark (or at the slot boundary when dead = 0).
    task automatic model_step();
        int unsigned period;
        int unsigned adv_at;
        for (int i = 0; i < 2; i++) begin
            period  = m_div[i] + m_dead[i];
            adv_at  = (m_dead[i] == 0) ? 0 : m_div[i];
            e_fd[i] = 1'b0;
            if (!en) begin
                m_act[i] = 1'b0;
                m_t[i]   = 0;
                m_d[i]   = 0;
            end else if (!m_act[i]) begin
                m_act[i] = 1'b1;
                m_t[i]   = 0;
                m_d[i]   = 0;
                m_n[i]   = norm(n_active);
            end else begin
                m_t[i] = (m_t[i] + 1) % period;
                if (m_t[i] == adv_at) begin
                    if (m_d[i] + 1 >= m_n[i]) begin
                        m_d[i]  = 0;
                        e_fd[i] = 1'b1;
                        m_n[i]  = norm(n_active);
                    end else begin
                        m_d[i] = m_d[i] + 1;
                    end
                end
            end
            e_sel[i] = m_act[i] ? 4'(m_d[i]) : 4'd0;
            if (m_act[i] && m_t[i] < m_div[i] && !blank_mask[m_d[i]])
                e_an[i] = ~(5'd1 << m_d[i]);
            else
                e_an[i] = 5'h1f;
        end
    endtask

    task automatic compare_all(input string pfx);
        check_eq({pfx, " sel_a"}, sel_a, e_sel[0]);
        check_eq({pfx, " an_a"},  an_a,  e_an[0]);
        check_eq({pfx, " fd_a"},  fd_a,  e_fd[0]);
        check_eq({pfx, " sel_b"}, sel_b, e_sel[1]);
        check_eq({pfx, " an_b"},  an_b,  e_an[1]);
        check_eq({pfx, " fd_b"},  fd_b,  e_fd[1]);
    endtask

    // One clock: inputs already set away from the edge; sample 1 time unit after.
    task automatic step(input string pfx);
        @(posedge clk);
        model_step();
        #1;
        compare_all(pfx);
    endtask

    // Reset pulled low between edges must clear outputs without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        m_div[0]  = DIV_A;
        m_dead[0] = DEAD_A;
        m_div[1]  = DIV_B;
        m_dead[1] = DEAD_B;

        rst_n      = 1'b0;
        en         = 1'b0;
        n_active   = 3'd5;
        blank_mask = 5'd0;
        model_reset();
        #12;
        compare_all("reset");
        rst_n = 1'b1;

        // Full 5-digit scan, unblanked
        en = 1'b1;
        for (int c = 0; c < 60; c++) step("basic");

        // Shrink to 3 digits mid-frame
        n_active = 3'd3;
        for (int c = 0; c < 60; c++) step("count");

        // Blank digit 2
        n_active   = 3'd5;
        blank_mask = 5'b00100;
        for (int c = 0; c < 60; c++) step("blank");
        blank_mask = 5'd0;

        // Drop enable for a few cycles, then restart
        en = 1'b0;
        for (int c = 0; c < 3; c++) step("en_low");
        en = 1'b1;
        for (int c = 0; c < 20; c++) step("en_restart");

        async_reset();
        for (int c = 0; c < 10; c++) step("post_rst");

        // Single digit and out-of-range counts
        n_active = 3'd1;
        for (int c = 0; c < 30; c++) step("n1");
        n_active = 3'd0;
        for (int c = 0; c < 40; c++) step("n0");
        n_active = 3'd7;
        for (int c = 0; c < 40; c++) step("n7");

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if (en) begin
                if ($urandom_range(0, 149) == 0) en = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                en = 1'b1;
            end
            if ($urandom_range(0, 79) == 0) n_active = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0) blank_mask = 5'($urandom & $urandom);
            if (c % 700 == 350) begin
                async_reset();
            end else begin
                step("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
